// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller slice.
package alu_issue_ctrl_pkg;

    localparam int OP_W     = 4;
    localparam int N_DEF    = 4;
    localparam int NREG_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Operand register file: two asynchronous read ports, one load port and one
// writeback port; writeback takes priority when both target the same entry.
module alu_issue_ctrl_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [N-1:0]  i_ld_data,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [N-1:0]  i_wb_data,
    input  logic [AW-1:0] i_rd_addr1,
    input  logic [AW-1:0] i_rd_addr0,
    output logic [N-1:0]  o_rd_data1,
    output logic [N-1:0]  o_rd_data0
);

    logic [N-1:0] r_regs [NREG];

    // Per-entry write: writeback beats a same-edge load to the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i_wb_en && (i_wb_addr == AW'(i))) begin
                    r_regs[i] <= i_wb_data;
                end else if (i_ld_en && (i_ld_addr == AW'(i))) begin
                    r_regs[i] <= i_ld_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    assign o_rd_data1 = r_regs[i_rd_addr1];
    assign o_rd_data0 = r_regs[i_rd_addr0];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts a command, presents registered operands to an
// external combinational ALU for one settling cycle, then writes the result back.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ld_en,
    input  logic [AW-1:0]   i_ld_addr,
    input  logic [N-1:0]    i_ld_data,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [OP_W-1:0] i_cmd_op,
    input  logic [AW-1:0]   i_cmd_rs1,
    input  logic [AW-1:0]   i_cmd_rs0,
    input  logic [AW-1:0]   i_cmd_rd,
    output logic [N-1:0]    o_alu_in1,
    output logic [N-1:0]    o_alu_in0,
    output logic [OP_W-1:0] o_alu_op,
    input  logic [N-1:0]    i_alu_out,
    output logic            o_res_valid,
    output logic [N-1:0]    o_res_data
);

    state_e          r_state;
    logic            r_cmd_ready;
    logic [N-1:0]    r_alu_in1;
    logic [N-1:0]    r_alu_in0;
    logic [OP_W-1:0] r_alu_op;
    logic [AW-1:0]   r_rd;
    logic            r_res_valid;
    logic [N-1:0]    r_res_data;

    logic [N-1:0]    w_rd_data1;
    logic [N-1:0]    w_rd_data0;
    logic            w_wb_en;

    // The regfile write lands on the same edge that leaves CAPTURE.
    assign w_wb_en = (r_state == ST_CAPTURE);

    alu_issue_ctrl_regfile #(
        .N    (N),
        .NREG (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ld_en    (i_ld_en),
        .i_ld_addr  (i_ld_addr),
        .i_ld_data  (i_ld_data),
        .i_wb_en    (w_wb_en),
        .i_wb_addr  (r_rd),
        .i_wb_data  (i_alu_out),
        .i_rd_addr1 (i_cmd_rs1),
        .i_rd_addr0 (i_cmd_rs0),
        .o_rd_data1 (w_rd_data1),
        .o_rd_data0 (w_rd_data0)
    );

    // Issue FSM with all handshake, operand and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_alu_in1   <= '0;
            r_alu_in0   <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_res_valid <= 1'b0;
                    if (i_cmd_valid) begin
                        r_alu_in1   <= w_rd_data1;
                        r_alu_in0   <= w_rd_data0;
                        r_alu_op    <= i_cmd_op;
                        r_rd        <= i_cmd_rd;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_res_data  <= i_alu_out;
                    r_res_valid <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_alu_in1   = r_alu_in1;
    assign o_alu_in0   = r_alu_in0;
    assign o_alu_op    = r_alu_op;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a small combinational ALU.
module tb_alu_issue_ctrl;

    localparam int N    = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [N-1:0]  ld_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rs1 = '0;
    logic [AW-1:0] cmd_rs0 = '0;
    logic [AW-1:0] cmd_rd = '0;
    logic [N-1:0]  alu_in1;
    logic [N-1:0]  alu_in0;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_out;
    logic          res_valid;
    logic [N-1:0]  res_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] hs_in1;
    logic [N-1:0] hs_in0;
    logic [3:0]   hs_op;
    logic [N-1:0] rd_val;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N), .NREG(NREG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ld_en     (ld_en),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_rs1   (cmd_rs1),
        .i_cmd_rs0   (cmd_rs0),
        .i_cmd_rd    (cmd_rd),
        .o_alu_in1   (alu_in1),
        .o_alu_in0   (alu_in0),
        .o_alu_op    (alu_op),
        .i_alu_out   (alu_out),
        .o_res_valid (res_valid),
        .o_res_data  (res_data)
    );

    // Downstream ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 pass a.
    function automatic logic [N-1:0] alu_f(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a & b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a ^ b;
            4'd5:    alu_f = ~a;
            4'd6:    alu_f = a;
            default: alu_f = '0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_op, alu_in1, alu_in0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // Full transaction; ld_when 1 = load on the handshake edge, 2 = on the writeback edge.
    task automatic do_cmd(input logic [3:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs0,
                          input logic [AW-1:0] rd, input int ld_when, input logic [AW-1:0] la,
                          input logic [N-1:0] ld_d);
        int guard = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs0 = rs0; cmd_rd = rd;
        while (!cmd_ready && guard < 10) begin
            step();
            guard++;
        end
        if (!cmd_ready) chk("hs_timeout", 32'd0, 32'd1);
        if (ld_when == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
        step();
        ld_en = 1'b0; cmd_valid = 1'b0;
        hs_in1 = alu_in1; hs_in0 = alu_in0; hs_op = alu_op;
        chk("issue_ready_low", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("capture_no_valid", {31'd0, res_valid}, 32'd0);
        if (ld_when == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
        step();
        ld_en = 1'b0;
        chk("res_valid_pulse", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic read_reg(input logic [AW-1:0] a);
        do_cmd(4'd6, a, a, a, 0, '0, '0);
        rd_val = res_data;
    endtask

    initial begin
        int acc;
        int pulses;
        int last_acc;
        int seen_valid;
        logic [N-1:0] sweep_exp [6];
        sweep_exp[0] = 4'h7; sweep_exp[1] = 4'hD; sweep_exp[2] = 4'h8;
        sweep_exp[3] = 4'hF; sweep_exp[4] = 4'h7; sweep_exp[5] = 4'h5;

        // Reset state
        #12;
        chk("rst_alu_in1", {28'd0, alu_in1}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {28'd0, res_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // First edge after release accepts a command
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_rs1 = 2'd0; cmd_rs0 = 2'd1; cmd_rd = 2'd3;
        step();
        cmd_valid = 1'b0;
        chk("first_accept", {31'd0, cmd_ready}, 32'd0);
        chk("first_op", {28'd0, alu_op}, 32'd3);
        step(); step();
        chk("first_valid", {31'd0, res_valid}, 32'd1);
        chk("first_data", {28'd0, res_data}, 32'd0);
        step();

        // Basic transaction
        load(2'd1, 4'hA);
        load(2'd0, 4'hD);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd2, 0, '0, '0);
        chk("basic_in1", {28'd0, hs_in1}, 32'hA);
        chk("basic_in0", {28'd0, hs_in0}, 32'hD);
        chk("basic_op", {28'd0, hs_op}, 32'h0);
        chk("basic_res", {28'd0, res_data}, 32'h7);
        step();
        chk("valid_one_cycle", {31'd0, res_valid}, 32'd0);
        chk("res_held", {28'd0, res_data}, 32'h7);
        chk("in1_held", {28'd0, alu_in1}, 32'hA);
        read_reg(2'd2);
        chk("r2_wb", {28'd0, rd_val}, 32'h7);

        // Back-to-back op sweep with cmd_valid held
        acc = 0; pulses = 0; last_acc = 0;
        cmd_rs1 = 2'd1; cmd_rs0 = 2'd0; cmd_rd = 2'd3;
        for (int c = 0; c < 24; c++) begin
            cmd_op = acc[3:0];
            cmd_valid = (acc < 6);
            if (cmd_ready && cmd_valid) begin
                if (acc > 0) chk("sweep_gap", c - last_acc, 32'd3);
                last_acc = c;
                acc++;
            end
            step();
            if (res_valid) begin
                if (pulses < 6) chk("sweep_res", {28'd0, res_data}, {28'd0, sweep_exp[pulses]});
                pulses++;
            end
        end
        cmd_valid = 1'b0;
        chk("sweep_accepts", acc, 32'd6);
        chk("sweep_pulses", pulses, 32'd6);

        // Writeback vs load on the same edge
        do_cmd(4'd2, 2'd1, 2'd0, 2'd2, 2, 2'd2, 4'hF);
        read_reg(2'd2);
        chk("wb_beats_ld", {28'd0, rd_val}, 32'h8);
        do_cmd(4'd0, 2'd1, 2'd0, 2'd2, 2, 2'd3, 4'hF);
        read_reg(2'd2);
        chk("wb_other_addr", {28'd0, rd_val}, 32'h7);
        read_reg(2'd3);
        chk("ld_other_addr", {28'd0, rd_val}, 32'hF);

        // rd == rs1 with a load to r1 on the handshake edge
        load(2'd1, 4'h3);
        do_cmd(4'd4, 2'd1, 2'd0, 2'd1, 1, 2'd1, 4'hC);
        chk("rbw_in1", {28'd0, hs_in1}, 32'h3);
        chk("rbw_res", {28'd0, res_data}, 32'hE);
        read_reg(2'd1);
        chk("rd_eq_rs1", {28'd0, rd_val}, 32'hE);

        // cmd_valid held with changing fields while busy
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_rs1 = 2'd1; cmd_rs0 = 2'd0; cmd_rd = 2'd3;
        step();
        cmd_op = 4'd5; cmd_rs1 = 2'd0; cmd_rs0 = 2'd1;
        step();
        chk("busy_in1", {28'd0, alu_in1}, 32'hE);
        chk("busy_op", {28'd0, alu_op}, 32'h2);
        cmd_op = 4'd1; cmd_rs1 = 2'd3;
        step();
        cmd_valid = 1'b0;
        chk("busy_in0", {28'd0, alu_in0}, 32'hD);
        chk("busy_op2", {28'd0, alu_op}, 32'h2);
        chk("busy_res", {28'd0, res_data}, 32'hC);
        step();

        // Reset during ISSUE
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rs1 = 2'd1; cmd_rs0 = 2'd0; cmd_rd = 2'd2;
        step();
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in1", {28'd0, alu_in1}, 32'd0);
        chk("arst_in0", {28'd0, alu_in0}, 32'd0);
        chk("arst_res_data", {28'd0, res_data}, 32'd0);
        chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
        seen_valid = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (res_valid) seen_valid++;
        end
        chk("arst_no_valid", seen_valid, 32'd0);
        read_reg(2'd1);
        chk("arst_r1", {28'd0, rd_val}, 32'd0);
        read_reg(2'd2);
        chk("arst_r2", {28'd0, rd_val}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter N, default 4, data width of registers and ALU operands.
REQ-002 Parameter NREG, default 4, number of operand registers; address width AW = clog2(NREG).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ld_en  input  1  load strobe, writes ld_data into register ld_addr.
REQ-006 ld_addr  input  AW  register index for load.
REQ-007 ld_data  input  N  load value.
REQ-008 cmd_valid  input  1  command offered.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-010 cmd_op  input  4  ALU opcode, passed through unmodified.
REQ-011 cmd_rs1, cmd_rs0, cmd_rd  input  AW each  source/destination register indices.
REQ-012 alu_in1, alu_in0  output  N  registered operands to the downstream ALU.
REQ-013 alu_op  output  4  registered opcode to the downstream ALU.
REQ-014 alu_out  input  N  combinational ALU result.
REQ-015 res_valid  output  1  one-cycle pulse, result written back.
REQ-016 res_data  output  N  captured result, held until next capture.

Function
REQ-017 FSM states: IDLE, ISSUE, CAPTURE; encoded as enum in the package.
REQ-018 IDLE: cmd_ready=1; on handshake latch regs[cmd_rs1]->alu_in1, regs[cmd_rs0]->alu_in0, cmd_op->alu_op, cmd_rd->internal rd; go ISSUE.
REQ-019 ISSUE: cmd_ready=0; operands stable for one full cycle for ALU settling; go CAPTURE unconditionally.
REQ-020 CAPTURE: sample alu_out into res_data and regs[rd]; res_valid=1 for this cycle only; go IDLE.
REQ-021 Latency: handshake edge to res_valid high = 2 cycles; sustained throughput one command per 3 cycles.
REQ-022 Operand read in REQ-018 sees register contents before any load on the same edge (read-before-write).
REQ-023 ld_en is honoured in every state.
REQ-024 Same edge, CAPTURE writeback and ld_en to the same address: writeback wins, load dropped; different addresses: both take effect.
REQ-025 cmd_rd may equal cmd_rs1 or cmd_rs0; sources already latched, result overwrites.
REQ-026 cmd_valid while not IDLE: ignored, no latching, no state change.
REQ-027 alu_in1/alu_in0/alu_op hold their value after CAPTURE until the next accepted command.
REQ-028 No width extension: alu_out taken as N bits; carry/overflow not tracked.

Reset
REQ-029 rst_n low asynchronously forces state IDLE, all registers 0, alu_in1=alu_in0=0, alu_op=0, res_data=0, res_valid=0; cmd_ready=1 after release.
REQ-030 Reset mid ISSUE/CAPTURE aborts command; no writeback, no res_valid.
REQ-031 First command accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package holds state enum, opcode width constant (4), and default N/NREG constants.
REQ-033 One sub-module natural: alu_regfile (NREG x N, two async read ports, one write port with writeback-over-load priority).
REQ-034 Downstream alu instantiated outside this block; bench connects both.

Verification
REQ-035 Load r1=0xA, r0=0xD; cmd op=0x0 rs1=1 rs0=0 rd=2 -> alu_in1=0xA, alu_in0=0xD, alu_op=0x0 next cycle; res_valid 2 cycles after handshake; r2=alu_out.
REQ-036 Sweep op=0x0..0x5 with same operands, back-to-back cmd_valid -> exactly one accept per 3 cycles, six res_valid pulses, res_data matches ALU model.
REQ-037 CAPTURE with rd=2 and ld_en addr=2 data=0xF same edge -> r2 holds ALU result, not 0xF; load to addr=3 same edge -> r3=0xF.
REQ-038 cmd rs1=1 rd=1 with r1=0x3 -> alu_in1=0x3, r1 replaced by result; read-before-write when ld to r1 coincides with handshake.
REQ-039 rst_n pulsed low during ISSUE -> all outputs 0 immediately, no res_valid, registers 0, cmd_ready=1 after release.
REQ-040 cmd_valid held high in ISSUE/CAPTURE with changing cmd fields -> alu_in1/in0/op unchanged until next IDLE handshake.
